// File: rtl/multi_chan_stim_seq.sv
// Multi-channel stimulus sequencer: drives arithmetic-progression words to NCHAN
// channels for NCYCLES steps and accumulates a per-channel signature of the response.
module multi_chan_stim_seq #(
  parameter int NCHAN    = 2,
  parameter int WIDTH    = 64,
  parameter int NCYCLES  = 5,
  parameter int STEP     = 10,
  parameter int SEED_MUL = 5,
  localparam int LONG_W  = 2*WIDTH+1,
  localparam int CW      = $clog2(NCYCLES+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      hold,
  input  logic [NCHAN*WIDTH-1:0]    x_in,
  output logic [NCHAN*WIDTH-1:0]    a_out,
  output logic [NCHAN*LONG_W-1:0]   long_out,
  output logic [NCHAN*WIDTH-1:0]    sig_out,
  output logic [CW-1:0]             cyc_out,
  output logic                      busy,
  output logic                      done
);

  // state  | meaning
  // IDLE   | out of reset, waiting for start
  // RUN    | one step per cycle unless hold is high
  // DONE   | sequence complete, results held until start or reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        r_state;
  logic [NCHAN-1:0][WIDTH-1:0]   r_a;
  logic [NCHAN-1:0][WIDTH-1:0]   r_sig;
  logic [CW-1:0]                 r_cyc;
  logic                          r_busy;
  logic                          r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_sig   <= '0;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < NCHAN; i++) begin
              r_a[i]   <= WIDTH'((i+1)*SEED_MUL);
              r_sig[i] <= '0;
            end
            r_cyc   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            // x_in is the response to the a value presented this cycle
            for (int i = 0; i < NCHAN; i++) begin
              r_a[i]   <= r_a[i] + WIDTH'(STEP);
              r_sig[i] <= r_sig[i] + x_in[i*WIDTH +: WIDTH];
            end
            r_cyc <= r_cyc + CW'(1);
            if (r_cyc == CW'(NCYCLES-1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out   = r_a;
  assign sig_out = r_sig;
  assign cyc_out = r_cyc;
  assign busy    = r_busy;
  assign done    = r_done;

  for (genvar g = 0; g < NCHAN; g++) begin : g_long
    assign long_out[g*LONG_W +: LONG_W] = {1'b0, r_a[g], r_a[g]};
  end

endmodule

// File: tb/tb_multi_chan_stim_seq.sv
// Bench for multi_chan_stim_seq: default-parameter instance checked every cycle
// against a step-count model, plus an 8-bit instance for the wrap-around case.
module tb_multi_chan_stim_seq;

  logic          clk = 1'b0;
  logic          rst_n, start, hold, loop;
  logic [127:0]  x_rand;
  logic [127:0]  x_in, a_out, sig_out;
  logic [257:0]  long_out;
  logic [2:0]    cyc_out;
  logic          busy, done;

  logic          start_w;
  logic [7:0]    a_w, sig_w;
  logic [16:0]   long_w;
  logic [2:0]    cyc_w;
  logic          busy_w, done_w;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign x_in = loop ? a_out : x_rand;

  multi_chan_stim_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .x_in(x_in),
    .a_out(a_out), .long_out(long_out), .sig_out(sig_out), .cyc_out(cyc_out),
    .busy(busy), .done(done)
  );

  multi_chan_stim_seq #(.NCHAN(1), .WIDTH(8), .NCYCLES(5), .STEP(100), .SEED_MUL(5)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .hold(1'b0), .x_in(a_w),
    .a_out(a_w), .long_out(long_w), .sig_out(sig_w), .cyc_out(cyc_w),
    .busy(busy_w), .done(done_w)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a is seed + STEP*steps, sig is the sum of responses taken.
  int           m_state;   // 0 idle, 1 run, 2 done
  int           m_steps;
  bit           m_seeded;
  bit           m_valid = 1'b0;
  logic [63:0]  m_sig [2];

  function automatic logic [63:0] exp_a(input int ch);
    if (!m_seeded) return 64'd0;
    return 64'((ch+1)*5) + 64'd10 * 64'(m_steps);
  endfunction

  always @(posedge clk) begin
    logic [63:0] xm [2];
    for (int ch = 0; ch < 2; ch++) xm[ch] = loop ? exp_a(ch) : x_rand[ch*64 +: 64];
    if (!rst_n) begin
      m_valid = 1'b1; m_state = 0; m_steps = 0; m_seeded = 1'b0;
      m_sig[0] = '0; m_sig[1] = '0;
    end else if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_steps = 0; m_seeded = 1'b1;
        m_sig[0] = '0; m_sig[1] = '0;
      end
    end else if (!hold) begin
      for (int ch = 0; ch < 2; ch++) m_sig[ch] = m_sig[ch] + xm[ch];
      m_steps++;
      if (m_steps == 5) m_state = 2;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk("model_a", a_out[ch*64 +: 64], exp_a(ch));
        chk("model_sig", sig_out[ch*64 +: 64], m_sig[ch]);
        chk("model_long", long_out[ch*129 +: 129], {1'b0, exp_a(ch), exp_a(ch)});
      end
      chk("model_cyc", cyc_out, m_steps);
      chk("model_busy", busy, m_state == 1);
      chk("model_done", done, m_state == 2);
    end
  end

  task automatic run_seq(input int hcnt, input bit glitch, output int n);
    int hleft;
    hleft = hcnt;
    start = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      hold  = 1'b0;
      if (n == 1) begin
        chk("seed_a0", a_out[63:0], 64'd5);
        chk("seed_a1", a_out[127:64], 64'd10);
        chk("seed_sig", sig_out, 128'd0);
        chk("seed_busy", busy, 1'b1);
        chk("seed_done", done, 1'b0);
      end
      if (done) break;
      if (n >= 40) begin
        chk("done_timeout", n, 0);
        break;
      end
      if (cyc_out == 3'd2 && hleft > 0) begin
        hold = 1'b1;
        hleft--;
      end else if (glitch && cyc_out == 3'd2) start = 1'b1;
    end
  endtask

  task automatic check_final(input int n, input int exp_n);
    logic [128:0] l0;
    l0 = {1'b0, 64'd55, 64'd55};
    chk("latency", n, exp_n);
    chk("fin_sig0", sig_out[63:0], 64'd125);
    chk("fin_sig1", sig_out[127:64], 64'd150);
    chk("fin_a0", a_out[63:0], 64'd55);
    chk("fin_a1", a_out[127:64], 64'd60);
    chk("fin_cyc", cyc_out, 3'd5);
    chk("fin_long0", long_out[128:0], l0);
    chk("fin_busy", busy, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] wexp [6];
    wexp = '{8'd5, 8'd105, 8'd205, 8'd49, 8'd149, 8'd249};
    rst_n = 1'b0; start = 1'b1; hold = 1'b0; loop = 1'b1; x_rand = '0; start_w = 1'b0;

    // reset wins over start
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a_out, 128'd0);
    chk("rst_sig", sig_out, 128'd0);
    chk("rst_cyc", cyc_out, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold_busy", busy, 1'b0);
    chk("idle_hold_a", a_out, 128'd0);

    run_seq(0, 1'b0, n);
    check_final(n, 6);

    // restart from DONE with a start pulse mid-run
    run_seq(0, 1'b1, n);
    check_final(n, 6);

    run_seq(3, 1'b0, n);
    check_final(n, 9);

    // reset in the middle of a run
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (cyc_out != 3'd2 && n < 20);
    chk("reach_cyc2", cyc_out, 3'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_a", a_out, 128'd0);
    chk("midrst_sig", sig_out, 128'd0);
    chk("midrst_cyc", cyc_out, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    run_seq(0, 1'b0, n);
    check_final(n, 6);

    // random responses, start, hold and reset
    loop = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      x_rand = {$urandom, $urandom, $urandom, $urandom};
      start  = ($urandom_range(0, 7) == 0);
      hold   = ($urandom_range(0, 3) == 0);
      rst_n  = ($urandom_range(0, 79) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; hold = 1'b0;

    // 8-bit wrap-around instance
    start_w = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start_w = 1'b0;
      chk("wrap_a", a_w, wexp[k]);
      chk("wrap_done", done_w, k == 5);
    end
    chk("wrap_sig", sig_w, 8'd1);
    chk("wrap_cyc", cyc_w, 3'd5);
    chk("wrap_long", long_w, {1'b0, 8'd249, 8'd249});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
